// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory bus signals shared between core, arbiter and memory
interface mem_port_arbiter_if;
    logic        i_req;
    logic [15:0] i_mem_pc;
    logic [31:0] i_mem_opcode;
    logic        i_mem_rdy;
    logic        d_mem_assert;
    logic        d_mem_cmd;
    logic [15:0] d_mem_addr;
    logic        d_mem_be0;
    logic        d_mem_be1;
    logic [15:0] d_mem_data_out;
    logic [15:0] d_mem_data_in;
    logic        d_mem_rdy;
    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [1:0]  m_be;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        m_ack;
    modport slave (
        input  i_req, i_mem_pc, d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_be0, d_mem_be1,
               d_mem_data_out, m_rdata, m_ack,
        output i_mem_opcode, i_mem_rdy, d_mem_data_in, d_mem_rdy, m_req, m_we, m_addr, m_be, m_wdata
    );
    modport master (
        output i_req, i_mem_pc, d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_be0, d_mem_be1,
               d_mem_data_out, m_rdata, m_ack,
        input  i_mem_opcode, i_mem_rdy, d_mem_data_in, d_mem_rdy, m_req, m_we, m_addr, m_be, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a 16-bit memory between a two-beat fetch port and a byte/word data port
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, DATA, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [15:0] op_hi_q, op_hi_d;
    logic [31:0] opcode_q, opcode_d;
    logic [15:0] data_in_q, data_in_d;
    logic        i_rdy_q, i_rdy_d;
    logic        d_rdy_q, d_rdy_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [15:0] m_addr_q, m_addr_d;
    logic [1:0]  m_be_q, m_be_d;
    logic [15:0] m_wdata_q, m_wdata_d;
    logic        word;
    logic        d_win;
    assign word  = bus.d_mem_be0 & bus.d_mem_be1;
    assign d_win = bus.d_mem_assert & (~bus.i_req | (streak_q < LIMIT));
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        op_hi_d   = op_hi_q;
        opcode_d  = opcode_q;
        data_in_d = data_in_q;
        i_rdy_d   = 1'b0;
        d_rdy_d   = 1'b0;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_be_d    = m_be_q;
        m_wdata_d = m_wdata_q;
        case (state_q)
            IDLE: begin
                streak_d = 4'd0;
                if (d_win) begin
                    state_d   = DATA;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_mem_cmd;
                    m_addr_d  = {bus.d_mem_addr[15:1], 1'b0};
                    m_be_d    = word ? 2'b11 : (bus.d_mem_addr[0] ? 2'b01 : 2'b10);
                    m_wdata_d = word ? bus.d_mem_data_out : {2{bus.d_mem_data_out[7:0]}};
                    streak_d  = !bus.i_req ? 4'd0 : (streak_q == LIMIT ? LIMIT : streak_q + 4'd1);
                end else if (bus.i_req) begin
                    state_d  = FETCH_HI;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = {bus.i_mem_pc[15:2], 2'b00};
                    m_be_d   = 2'b11;
                end
            end
            FETCH_HI: if (bus.m_ack) begin
                op_hi_d  = bus.m_rdata;
                m_addr_d = {m_addr_q[15:2], 2'b10};
                state_d  = FETCH_LO;
            end
            FETCH_LO: if (bus.m_ack) begin
                opcode_d = {op_hi_q, bus.m_rdata};
                i_rdy_d  = 1'b1;
                m_req_d  = 1'b0;
                state_d  = RESP;
            end
            DATA: if (bus.m_ack) begin
                // the stored lane enables tell which byte a byte read returns
                data_in_d = m_we_q ? data_in_q :
                            m_be_q == 2'b11 ? bus.m_rdata :
                            {8'h00, m_be_q[0] ? bus.m_rdata[7:0] : bus.m_rdata[15:8]};
                d_rdy_d   = 1'b1;
                m_req_d   = 1'b0;
                state_d   = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            op_hi_q   <= '0;
            opcode_q  <= '0;
            data_in_q <= '0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            op_hi_q   <= op_hi_d;
            opcode_q  <= opcode_d;
            data_in_q <= data_in_d;
            i_rdy_q   <= i_rdy_d;
            d_rdy_q   <= d_rdy_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_be_q    <= m_be_d;
            m_wdata_q <= m_wdata_d;
        end
    end
    assign bus.i_mem_opcode  = opcode_q;
    assign bus.i_mem_rdy     = i_rdy_q;
    assign bus.d_mem_data_in = data_in_q;
    assign bus.d_mem_rdy     = d_rdy_q;
    assign bus.m_req         = m_req_q;
    assign bus.m_we          = m_we_q;
    assign bus.m_addr        = m_addr_q;
    assign bus.m_be          = m_be_q;
    assign bus.m_wdata       = m_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a wait-state memory model behind the arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_port_arbiter_if bus ();
    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] fq[$];
    logic [15:0] dq[$];
    logic [15:0] mem [0:255];
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [15:0] acc_addr, acc_wdata, trace_pc;
    logic [1:0]  acc_be;
    logic        acc_we;
    logic [31:0] trace_bits;
    int trace_len;
    int n_irdy = 0;
    logic [15:0] last_rd = 16'h0000;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    assign bus.m_ack   = bus.m_req && (wait_cnt >= ack_delay);
    assign bus.m_rdata = mem[bus.m_addr[8:1]];
    always @(posedge clk) begin
        if (bus.m_req && bus.m_ack && bus.m_we) begin
            if (bus.m_be[1]) mem[bus.m_addr[8:1]][15:8] = bus.m_wdata[15:8];
            if (bus.m_be[0]) mem[bus.m_addr[8:1]][7:0] = bus.m_wdata[7:0];
        end
        wait_cnt <= (!bus.m_req || bus.m_ack) ? 0 : wait_cnt + 1;
    end
    always @(negedge clk) begin
        if (bus.m_req && bus.m_ack) begin
            acc_addr   = bus.m_addr;
            acc_we     = bus.m_we;
            acc_be     = bus.m_be;
            acc_wdata  = bus.m_wdata;
            trace_bits = {trace_bits[30:0], bus.m_addr[15:2] == trace_pc[15:2]};
            trace_len++;
        end
        if (bus.i_mem_rdy) begin
            n_irdy++;
            if (fq.size() == 0) check("i_rdy_unexpected", 32'd1, 32'd0);
            else check("opcode", bus.i_mem_opcode, fq.pop_front());
        end
        if (bus.d_mem_rdy) begin
            if (dq.size() == 0) check("d_rdy_unexpected", 32'd1, 32'd0);
            else check("data_in", {16'h0, bus.d_mem_data_in}, {16'h0, dq.pop_front()});
        end
        if (!rst) check("rdy_exclusive", {31'h0, bus.i_mem_rdy & bus.d_mem_rdy}, 32'd0);
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_fetch(input logic [15:0] pc, input logic [31:0] exp, output int cyc);
        bus.i_mem_pc = pc;
        bus.i_req = 1'b1;
        fq.push_back(exp);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.i_mem_rdy && cyc < 100);
        bus.i_req = 1'b0;
    endtask
    task automatic do_data(input logic we, input logic [15:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, input logic [15:0] exp_rd, output int cyc);
        bus.d_mem_cmd = we;
        bus.d_mem_addr = addr;
        bus.d_mem_be0 = be[0];
        bus.d_mem_be1 = be[1];
        bus.d_mem_data_out = wd;
        bus.d_mem_assert = 1'b1;
        if (!we) last_rd = exp_rd;
        dq.push_back(last_rd);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.d_mem_rdy && cyc < 100);
        bus.d_mem_assert = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int cyc;
        int f_done;
        int k;
        int irdy_before;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h04] = 16'h1010;
        mem[8'h05] = 16'h0000;
        mem[8'h51] = 16'h1234;
        mem[8'h08] = 16'h1111;
        mem[8'h09] = 16'h2222;
        mem[8'h10] = 16'hABCD;
        mem[8'h11] = 16'h1357;
        trace_pc = 16'h0010;
        trace_bits = 0;
        trace_len = 0;
        bus.i_req = 1'b1;
        bus.i_mem_pc = 16'h0008;
        bus.d_mem_assert = 1'b0;
        bus.d_mem_cmd = 1'b0;
        bus.d_mem_addr = 16'h0000;
        bus.d_mem_be0 = 1'b0;
        bus.d_mem_be1 = 1'b0;
        bus.d_mem_data_out = 16'h0000;
        rst = 1'b1;
        tick();
        check("rst_m_req_c1", {31'h0, bus.m_req}, 32'd0);
        tick();
        check("rst_m_req_c2", {31'h0, bus.m_req}, 32'd0);
        check("rst_i_rdy", {31'h0, bus.i_mem_rdy}, 32'd0);
        check("rst_d_rdy", {31'h0, bus.d_mem_rdy}, 32'd0);
        check("rst_opcode", bus.i_mem_opcode, 32'h0);
        check("rst_data_in", {16'h0, bus.d_mem_data_in}, 32'h0);
        rst = 1'b0;
        fq.push_back(32'h10100000);
        tick();
        check("fetch_hi_req", {31'h0, bus.m_req}, 32'd1);
        check("fetch_hi_addr", {16'h0, bus.m_addr}, 32'h0008);
        check("fetch_hi_be", {30'h0, bus.m_be}, 32'd3);
        tick();
        check("fetch_lo_addr", {16'h0, bus.m_addr}, 32'h000A);
        check("fetch_lo_req", {31'h0, bus.m_req}, 32'd1);
        tick();
        check("fetch_rdy_c3", {31'h0, bus.i_mem_rdy}, 32'd1);
        bus.i_req = 1'b0;
        tick();
        check("fetch_rdy_pulse", {31'h0, bus.i_mem_rdy}, 32'd0);
        tick();
        do_data(1'b1, 16'h00A0, 2'b11, 16'hC000, 16'h0, cyc);
        check("wr_latency", cyc, 32'd2);
        check("wr_we", {31'h0, acc_we}, 32'd1);
        check("wr_be", {30'h0, acc_be}, 32'd3);
        check("wr_addr", {16'h0, acc_addr}, 32'h00A0);
        check("wr_wdata", {16'h0, acc_wdata}, 32'hC000);
        tick();
        do_data(1'b0, 16'h00A3, 2'b01, 16'h0, 16'h0034, cyc);
        check("brd_addr", {16'h0, acc_addr}, 32'h00A2);
        check("brd_be", {30'h0, acc_be}, 32'd1);
        check("brd_we", {31'h0, acc_we}, 32'd0);
        tick();
        do_data(1'b1, 16'h00A2, 2'b01, 16'h0077, 16'h0, cyc);
        check("bwr_be", {30'h0, acc_be}, 32'd2);
        check("bwr_wdata", {16'h0, acc_wdata}, 32'h7777);
        tick();
        do_data(1'b0, 16'h00A3, 2'b11, 16'h0, 16'h7734, cyc);
        check("misaligned_addr", {16'h0, acc_addr}, 32'h00A2);
        check("misaligned_lat", cyc, 32'd2);
        tick();
        for (int i = 0; i < 8; i++) dq.push_back(16'hC000);
        fq.push_back(32'h11112222);
        fq.push_back(32'h11112222);
        last_rd = 16'hC000;
        trace_bits = 0;
        trace_len = 0;
        bus.d_mem_cmd = 1'b0;
        bus.d_mem_addr = 16'h00A0;
        bus.d_mem_be0 = 1'b1;
        bus.d_mem_be1 = 1'b1;
        bus.d_mem_assert = 1'b1;
        bus.i_mem_pc = 16'h0010;
        bus.i_req = 1'b1;
        f_done = 0;
        k = 0;
        do begin
            tick();
            k++;
            if (bus.i_mem_rdy) f_done++;
        end while (f_done < 2 && k < 300);
        bus.i_req = 1'b0;
        bus.d_mem_assert = 1'b0;
        tick();
        tick();
        check("contention_len", trace_len, 32'd12);
        check("contention_order", trace_bits & 32'hFFF, 32'h0C3);
        ack_delay = 3;
        do_fetch(16'h0020, 32'hABCD1357, cyc);
        check("wait_latency", cyc, 32'd9);
        tick();
        bus.i_mem_pc = 16'h0030;
        bus.i_req = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.m_addr != 16'h0032 && k < 50);
        check("reach_fetch_lo", {16'h0, bus.m_addr}, 32'h0032);
        irdy_before = n_irdy;
        rst = 1'b1;
        bus.i_req = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_m_req", {31'h0, bus.m_req}, 32'd0);
        check("abort_opcode", bus.i_mem_opcode, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        check("abort_no_rdy", n_irdy, irdy_before);
        check("abort_opcode_hold", bus.i_mem_opcode, 32'h0);
        check("fq_empty", fq.size(), 32'd0);
        check("dq_empty", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
